rvc_fetch_aligner: RTL and testbench

//  Sits between the IF stage's PC and the ICACHE. Turns 32-bit word-addressed ICACHE reads into
//  one aligned instruction at the current pc, 16-bit (RVC) or 32-bit, including 32-bit instructions

---
 rtl/rvc_fetch_aligner.sv | 135 +++++++++++++
 tb/tb_rvc_fetch_aligner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner
//   Aligns RVC (16-bit) and 32-bit instructions at the IF-stage pc out of a
//   32-bit word-addressed ICACHE. A 2-entry word buffer (word X lives in entry
//   X[0]) lets sequential code reuse fetched words. It also lets a 32-bit
//   instruction that straddles a word boundary be assembled from two words.
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   pc                    byte address of the requested instruction (pc[0]=0)
//   ready                 inst/compressed valid for pc this cycle
//   compressed            inst holds a 16-bit instruction in inst[15:0]
//   inst                  aligned instruction; NOP when not ready
//   ICACHE_ren/addr       word read request (held stable while stalled)
//   ICACHE_wen/wdata      unused write path, tied 0
//   ICACHE_rdata/stall    read data / busy indication from the cache
module rvc_fetch_aligner #(
    parameter bit          BYTE_SWAP = 1'b1,
    parameter logic [31:0] NOP       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        ready,
    output logic        compressed,
    output logic [31:0] inst,
    output logic        ICACHE_ren,
    output logic        ICACHE_wen,
    output logic [29:0] ICACHE_addr,
    output logic [31:0] ICACHE_wdata,
    input  logic [31:0] ICACHE_rdata,
    input  logic        ICACHE_stall
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]  state;
    logic [29:0] lat_addr;
    logic        bf_valid [2];
    logic [29:0] bf_tag   [2];
    logic [31:0] bf_data  [2];

    logic [29:0] a, a1, need_addr;
    logic        h, hit_a, hit_a1, need_req, done;
    logic        avail_a, avail_a1, rdy, cmp;
    logic [31:0] rdata_sw, word_a, word_a1, inst_c;

    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = '0;

    assign rdata_sw = BYTE_SWAP ? {ICACHE_rdata[7:0], ICACHE_rdata[15:8],
                                   ICACHE_rdata[23:16], ICACHE_rdata[31:24]}
                                : ICACHE_rdata;

    always_comb begin
        a      = pc[31:2];
        h      = pc[1];
        a1     = a + 30'd1;   // wraps at the top of the 30-bit word space
        hit_a  = bf_valid[a[0]]  && (bf_tag[a[0]]  == a);
        hit_a1 = bf_valid[a1[0]] && (bf_tag[a1[0]] == a1);

        // The second word is only needed once the first word is known to
        // hold the lower half of a straddling 32-bit instruction.
        need_req  = 1'b0;
        need_addr = a;
        if (!hit_a) begin
            need_req  = 1'b1;
            need_addr = a;
        end else if (h && (bf_data[a[0]][17:16] == 2'b11) && !hit_a1) begin
            need_req  = 1'b1;
            need_addr = a1;
        end

        ICACHE_ren  = rst_n && ((state == S_BUSY) || need_req);
        ICACHE_addr = (state == S_BUSY) ? lat_addr : need_addr;
        done        = ICACHE_ren && !ICACHE_stall;

        // Same-cycle forwarding of a completing read. A completion that does
        // not match the current pc's words (a stale BUSY request) is ignored.
        avail_a  = hit_a  || (done && (ICACHE_addr == a));
        avail_a1 = hit_a1 || (done && (ICACHE_addr == a1));
        word_a   = hit_a  ? bf_data[a[0]]  : rdata_sw;
        word_a1  = hit_a1 ? bf_data[a1[0]] : rdata_sw;

        if (!h) begin
            rdy    = avail_a;
            cmp    = (word_a[1:0] != 2'b11);
            inst_c = cmp ? {16'b0, word_a[15:0]} : word_a;
        end else if (word_a[17:16] != 2'b11) begin
            rdy    = avail_a;
            cmp    = 1'b1;
            inst_c = {16'b0, word_a[31:16]};
        end else begin
            rdy    = avail_a && avail_a1;
            cmp    = 1'b0;
            inst_c = {word_a1[15:0], word_a[31:16]};
        end

        if (rst_n && rdy) begin
            ready      = 1'b1;
            compressed = cmp;
            inst       = inst_c;
        end else begin
            ready      = 1'b0;
            compressed = 1'b0;
            inst       = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lat_addr    <= '0;
            bf_valid[0] <= 1'b0;
            bf_valid[1] <= 1'b0;
            bf_tag[0]   <= '0;
            bf_tag[1]   <= '0;
            bf_data[0]  <= '0;
            bf_data[1]  <= '0;
        end else begin
            if (done) begin
                bf_valid[ICACHE_addr[0]] <= 1'b1;
                bf_tag[ICACHE_addr[0]]   <= ICACHE_addr;
                bf_data[ICACHE_addr[0]]  <= rdata_sw;
            end
            case (state)
                S_IDLE: if (ICACHE_ren && ICACHE_stall) begin
                    state    <= S_BUSY;
                    lat_addr <= ICACHE_addr;
                end
                default: if (!ICACHE_stall) state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
module tb_rvc_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        ready, compressed;
    logic [31:0] inst;
    logic        ICACHE_ren, ICACHE_wen;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_wdata, ICACHE_rdata;
    logic        ICACHE_stall;
    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ICACHE_rdata = mem[ICACHE_addr[5:0]];

    rvc_fetch_aligner #(.BYTE_SWAP(1'b0), .NOP(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .ready(ready),
        .compressed(compressed), .inst(inst),
        .ICACHE_ren(ICACHE_ren), .ICACHE_wen(ICACHE_wen),
        .ICACHE_addr(ICACHE_addr), .ICACHE_wdata(ICACHE_wdata),
        .ICACHE_rdata(ICACHE_rdata), .ICACHE_stall(ICACHE_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs, let combinational outputs settle (well after the edge).
    task automatic drive(input logic r, input logic [31:0] p, input logic s);
        rst_n        = r;
        pc           = p;
        ICACHE_stall = s;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        @(posedge clk);
        #1;

        // Reset cycle outputs
        drive(1'b0, 32'h0, 1'b0);
        chk("rst_ren", {31'b0, ICACHE_ren}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_comp", {31'b0, compressed}, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("wen", {31'b0, ICACHE_wen}, 32'd0);
        chk("wdata", ICACHE_wdata, 32'd0);
        tick();

        // 1: 32-bit instruction with zero added latency
        mem[0] = 32'h00A0_0093;
        drive(1'b1, 32'h0, 1'b0);
        chk("t1_ren", {31'b0, ICACHE_ren}, 32'd1);
        chk("t1_addr", {2'b0, ICACHE_addr}, 32'd0);
        chk("t1_ready", {31'b0, ready}, 32'd1);
        chk("t1_comp", {31'b0, compressed}, 32'd0);
        chk("t1_inst", inst, 32'h00A0_0093);
        tick();

        // 2: two RVC instructions out of one fetched word
        do_reset();
        mem[0] = 32'h4505_4501;
        drive(1'b1, 32'h0, 1'b0);
        chk("t2_c0_inst", inst, 32'h0000_4501);
        chk("t2_c0_comp", {31'b0, compressed}, 32'd1);
        tick();
        drive(1'b1, 32'h2, 1'b0);
        chk("t2_c1_ren", {31'b0, ICACHE_ren}, 32'd0);
        chk("t2_c1_ready", {31'b0, ready}, 32'd1);
        chk("t2_c1_comp", {31'b0, compressed}, 32'd1);
        chk("t2_c1_inst", inst, 32'h0000_4505);
        tick();

        // 3: straddling 32-bit instruction, two accesses
        do_reset();
        mem[0] = 32'h0093_4501;
        mem[1] = 32'h0000_00A0;
        drive(1'b1, 32'h2, 1'b0);
        chk("t3_c0_addr", {2'b0, ICACHE_addr}, 32'd0);
        chk("t3_c0_ready", {31'b0, ready}, 32'd0);
        chk("t3_c0_inst", inst, 32'h0000_0013);
        tick();
        drive(1'b1, 32'h2, 1'b0);
        chk("t3_c1_ren", {31'b0, ICACHE_ren}, 32'd1);
        chk("t3_c1_addr", {2'b0, ICACHE_addr}, 32'd1);
        chk("t3_c1_ready", {31'b0, ready}, 32'd1);
        chk("t3_c1_comp", {31'b0, compressed}, 32'd0);
        chk("t3_c1_inst", inst, 32'h00A0_0093);
        tick();

        // 4: stalled miss, request held
        mem[4] = 32'h00B0_0113;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 32'h10, 1'b1);
            chk("t4_stall_ren", {31'b0, ICACHE_ren}, 32'd1);
            chk("t4_stall_addr", {2'b0, ICACHE_addr}, 32'd4);
            chk("t4_stall_ready", {31'b0, ready}, 32'd0);
            tick();
        end
        drive(1'b1, 32'h10, 1'b0);
        chk("t4_done_ready", {31'b0, ready}, 32'd1);
        chk("t4_done_inst", inst, 32'h00B0_0113);
        tick();

        // 5: pc correction while BUSY
        do_reset();
        mem[16] = 32'h0030_0193;
        drive(1'b1, 32'h10, 1'b1);
        tick();
        drive(1'b1, 32'h10, 1'b1);
        chk("t5_b1_addr", {2'b0, ICACHE_addr}, 32'd4);
        tick();
        drive(1'b1, 32'h40, 1'b1);
        chk("t5_b2_addr", {2'b0, ICACHE_addr}, 32'd4);
        chk("t5_b2_ready", {31'b0, ready}, 32'd0);
        tick();
        drive(1'b1, 32'h40, 1'b0);
        chk("t5_fin_addr", {2'b0, ICACHE_addr}, 32'd4);
        chk("t5_fin_ready", {31'b0, ready}, 32'd0);
        chk("t5_fin_inst", inst, 32'h0000_0013);
        tick();
        drive(1'b1, 32'h40, 1'b0);
        chk("t5_new_addr", {2'b0, ICACHE_addr}, 32'h10);
        chk("t5_new_ready", {31'b0, ready}, 32'd1);
        chk("t5_new_inst", inst, 32'h0030_0193);
        tick();

        // 6: reset during BUSY clears the buffer
        mem[0] = 32'h00A0_0093;
        drive(1'b1, 32'h0, 1'b0);
        chk("t6_fill_ready", {31'b0, ready}, 32'd1);
        tick();
        drive(1'b1, 32'h20, 1'b1);
        tick();
        drive(1'b0, 32'h20, 1'b1);
        chk("t6_rst_ren", {31'b0, ICACHE_ren}, 32'd0);
        chk("t6_rst_ready", {31'b0, ready}, 32'd0);
        tick();
        drive(1'b1, 32'h0, 1'b0);
        chk("t6_refetch_ren", {31'b0, ICACHE_ren}, 32'd1);
        chk("t6_refetch_addr", {2'b0, ICACHE_addr}, 32'd0);
        tick();

        // 7: straddle across the top of the address space (A+1 wraps to 0)
        do_reset();
        mem[63] = 32'h0093_0000;
        mem[0]  = 32'h0000_00A0;
        drive(1'b1, 32'hFFFF_FFFE, 1'b0);
        chk("t7_c0_addr", {2'b0, ICACHE_addr}, 32'h3FFF_FFFF);
        chk("t7_c0_ready", {31'b0, ready}, 32'd0);
        tick();
        drive(1'b1, 32'hFFFF_FFFE, 1'b0);
        chk("t7_c1_addr", {2'b0, ICACHE_addr}, 32'd0);
        chk("t7_c1_ready", {31'b0, ready}, 32'd1);
        chk("t7_c1_inst", inst, 32'h00A0_0093);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
